// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: sequences BRAM fetches, systolic core runs and output writes over all output tiles
module matmul_tile_scheduler #(
    parameter int INNER_BLOCKS = 2,
    parameter int ROW_TILES    = 3,
    parameter int COL_TILES    = 3,
    parameter int ADDR_WIDTH_I = 4,
    parameter int ADDR_WIDTH_W = 4,
    parameter int ADDR_WIDTH_O = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    in_rd_en,
    output logic [ADDR_WIDTH_I-1:0] in_rd_addr,
    output logic                    wb_rd_en,
    output logic [ADDR_WIDTH_W-1:0] wb_rd_addr,
    output logic                    core_en,
    output logic                    core_rst_n,
    output logic                    core_acc_clr_n,
    input  logic                    core_sys_finish,
    input  logic                    core_acc_done,
    output logic                    out_wr_en,
    output logic [ADDR_WIDTH_O-1:0] out_addr,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, RUN, NEXT, WAIT_ACC, WRITE, DONE} state_t;

    localparam logic [15:0] IB = 16'(INNER_BLOCKS);
    localparam logic [15:0] RT = 16'(ROW_TILES);
    localparam logic [15:0] CT = 16'(COL_TILES);

    state_t      state, state_nxt;
    logic [15:0] k, row, col;
    logic [15:0] k_nxt, row_nxt, col_nxt;
    logic [ADDR_WIDTH_I-1:0] in_addr_nxt;
    logic [ADDR_WIDTH_W-1:0] wb_addr_nxt;
    logic [ADDR_WIDTH_O-1:0] out_addr_nxt;

    // Next state and counters; strobes only matter in the state that waits for them, abort overrides all
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        row_nxt   = row;
        col_nxt   = col;
        case (state)
            IDLE, DONE: if (start) begin
                state_nxt = CLEAR;
                k_nxt     = '0;
                row_nxt   = '0;
                col_nxt   = '0;
            end
            CLEAR:    state_nxt = FETCH;
            FETCH:    state_nxt = RUN;
            RUN:      state_nxt = core_sys_finish ? NEXT : RUN;
            NEXT: begin
                state_nxt = (k == IB - 16'd1) ? WAIT_ACC : FETCH;
                k_nxt     = (k == IB - 16'd1) ? k : k + 16'd1;
            end
            WAIT_ACC: if (core_acc_done) begin
                state_nxt = WRITE;
                k_nxt     = '0;
            end
            WRITE: if (out_ready) begin
                state_nxt = (row == RT - 16'd1 && col == CT - 16'd1) ? DONE : CLEAR;
                col_nxt   = (state_nxt == DONE) ? col : (col == CT - 16'd1) ? 16'd0 : col + 16'd1;
                row_nxt   = (state_nxt == DONE || col != CT - 16'd1) ? row : row + 16'd1;
            end
            default:  state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            k_nxt     = '0;
            row_nxt   = '0;
            col_nxt   = '0;
        end
    end

    assign in_addr_nxt  = ADDR_WIDTH_I'(k_nxt + IB * row_nxt);
    assign wb_addr_nxt  = ADDR_WIDTH_W'(k_nxt + IB * col_nxt);
    assign out_addr_nxt = ADDR_WIDTH_O'(row_nxt * CT + col_nxt);

    // State, counters and outputs all registered; outputs decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            k              <= '0;
            row            <= '0;
            col            <= '0;
            in_rd_en       <= 1'b0;
            wb_rd_en       <= 1'b0;
            in_rd_addr     <= '0;
            wb_rd_addr     <= '0;
            core_en        <= 1'b0;
            core_rst_n     <= 1'b0;
            core_acc_clr_n <= 1'b0;
            out_wr_en      <= 1'b0;
            out_addr       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_nxt;
            k              <= k_nxt;
            row            <= row_nxt;
            col            <= col_nxt;
            in_rd_en       <= state_nxt == FETCH;
            wb_rd_en       <= state_nxt == FETCH;
            in_rd_addr     <= (state_nxt == FETCH) ? in_addr_nxt : in_rd_addr;
            wb_rd_addr     <= (state_nxt == FETCH) ? wb_addr_nxt : wb_rd_addr;
            core_en        <= state_nxt == RUN || state_nxt == WAIT_ACC;
            core_rst_n     <= !(state_nxt == CLEAR || state_nxt == NEXT);
            core_acc_clr_n <= state_nxt != CLEAR;
            out_wr_en      <= state_nxt == WRITE;
            out_addr       <= (state_nxt == WRITE) ? out_addr_nxt : out_addr;
            busy           <= !(state_nxt == IDLE || state_nxt == DONE);
            done           <= state_nxt == DONE;
        end
    end
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// tb_matmul_tile_scheduler: directed job sequences with a core model and an output-address scoreboard
module tb_matmul_tile_scheduler;
    localparam int IB      = 2;
    localparam int FIN_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;
    logic       spur_fin = 1'b0;
    logic       model_fin = 1'b0;
    logic       model_acc = 1'b0;
    logic       in_rd_en, wb_rd_en, core_en, core_rst_n, core_acc_clr_n;
    logic       out_wr_en, busy, done;
    logic [3:0] in_rd_addr, wb_rd_addr, out_addr;
    logic       core_sys_finish, core_acc_done;

    int total = 0;
    int bad = 0;
    int writes = 0;
    int run_cnt = 0;
    int fin_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] f_in[$];
    logic [3:0] f_wb[$];

    assign core_sys_finish = model_fin | spur_fin;
    assign core_acc_done   = model_acc;

    matmul_tile_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr),
        .core_en(core_en), .core_rst_n(core_rst_n), .core_acc_clr_n(core_acc_clr_n),
        .core_sys_finish(core_sys_finish), .core_acc_done(core_acc_done),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core model: finish after FIN_LAT enabled cycles, accumulation done once IB finishes have been seen
    always @(negedge clk) begin
        model_fin = 1'b0;
        model_acc = 1'b0;
        if (!busy || !core_acc_clr_n) begin
            run_cnt = 0;
            fin_cnt = 0;
        end else if (core_en) begin
            if (fin_cnt == IB) begin
                model_acc = 1'b1;
                fin_cnt = 0;
            end else begin
                run_cnt++;
                if (run_cnt == FIN_LAT) begin
                    model_fin = 1'b1;
                    run_cnt = 0;
                    fin_cnt++;
                end
            end
        end
    end

    // Monitor: record fetch addresses, pop the scoreboard on every accepted write
    always @(negedge clk) begin
        if (in_rd_en) begin
            f_in.push_back(in_rd_addr);
            f_wb.push_back(wb_rd_addr);
        end
        if (out_wr_en && out_ready) begin
            writes++;
            if (exp_q.size() == 0) chk("unexpected_write", 32'(out_addr), 32'hFFFF);
            else chk("out_addr", 32'(out_addr), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int wbase;
        int fbase;
        int bp_w;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_rd_en", 32'(in_rd_en), 0);
        chk("rst_wb_rd_en", 32'(wb_rd_en), 0);
        chk("rst_addrs", {in_rd_addr, wb_rd_addr, out_addr}, 0);
        chk("rst_core_en", 32'(core_en), 0);
        chk("rst_core_rst_n", 32'(core_rst_n), 0);
        chk("rst_acc_clr_n", 32'(core_acc_clr_n), 0);
        chk("rst_out_wr_en", 32'(out_wr_en), 0);
        chk("rst_busy_done", {busy, done}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_core_rst_n", 32'(core_rst_n), 1);
        chk("idle_acc_clr_n", 32'(core_acc_clr_n), 1);
        chk("idle_busy", 32'(busy), 0);
        spur_fin = 1'b1;
        tick();
        spur_fin = 1'b0;
        tick();
        chk("spur_busy", 32'(busy), 0);
        chk("spur_core_en", 32'(core_en), 0);
        for (int i = 0; i < 9; i++) exp_q.push_back(4'(i));
        fbase = f_in.size();
        wbase = writes;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_busy", 32'(busy), 1);
        chk("clear_core_rst_n", 32'(core_rst_n), 0);
        chk("clear_acc_clr_n", 32'(core_acc_clr_n), 0);
        tick();
        chk("fetch0_en", {in_rd_en, wb_rd_en}, 2'b11);
        chk("fetch0_addr", {in_rd_addr, wb_rd_addr}, 0);
        for (int i = 0; i < 2000 && !done; i++) begin
            start = (i == 30);
            tick();
        end
        start = 1'b0;
        chk("job_done", 32'(done), 1);
        chk("job_busy", 32'(busy), 0);
        chk("job_writes", 32'(writes - wbase), 9);
        chk("job_fetches", 32'(f_in.size() - fbase), 18);
        chk("job_queue_empty", 32'(exp_q.size()), 0);
        if (f_in.size() >= fbase + 12) begin
            chk("t5_in_addr", {f_in[fbase + 10], f_in[fbase + 11]}, {4'd2, 4'd3});
            chk("t5_wb_addr", {f_wb[fbase + 10], f_wb[fbase + 11]}, {4'd4, 4'd5});
        end else chk("t5_fetches", 32'(f_in.size() - fbase), 32'(12));
        tick();
        chk("done_sticky", 32'(done), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(4'(i));
        wbase = writes;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_done", 32'(done), 0);
        chk("restart_clear", {busy, core_acc_clr_n}, 2'b10);
        for (int i = 0; i < 200 && !out_wr_en; i++) tick();
        chk("bp_reach_write", 32'(out_wr_en), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wr_en", 32'(out_wr_en), 1);
            chk("bp_core_en", 32'(core_en), 0);
            chk("bp_out_addr", 32'(out_addr), 0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_wr_en_6th", 32'(out_wr_en), 1);
        bp_w = writes;
        tick();
        chk("bp_released", 32'(out_wr_en), 0);
        chk("bp_one_write", 32'(writes - bp_w), 1);
        for (int i = 0; i < 500 && !(writes - wbase == 4 && core_en); i++) tick();
        chk("abort_reach_t4", 32'(writes - wbase), 4);
        chk("abort_in_run", 32'(core_en), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy_done", {busy, done}, 0);
        chk("abort_core_en", 32'(core_en), 0);
        chk("abort_queue_empty", 32'(exp_q.size()), 0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_over_start", 32'(busy), 0);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        wbase = writes;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 500 && !(writes - wbase == 2 && core_en && fin_cnt == IB); i++) tick();
        chk("rst_reach_wait_acc", {32'(writes - wbase), 32'(fin_cnt)}, {32'd2, 32'(IB)});
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_en", {in_rd_en, wb_rd_en}, 0);
        chk("arst_addrs", {in_rd_addr, wb_rd_addr, out_addr}, 0);
        chk("arst_core", {core_en, core_rst_n, core_acc_clr_n}, 0);
        chk("arst_out_wr_en", 32'(out_wr_en), 0);
        chk("arst_busy_done", {busy, done}, 0);
        tick();
        tick();
        chk("arst_no_write", 32'(writes - wbase), 2);
        chk("arst_queue_empty", 32'(exp_q.size()), 0);
        rst_n = 1'b1;
        tick();
        chk("arst_idle", {busy, core_rst_n}, 2'b01);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matmul_tile_scheduler.md
MATMUL_TILE_SCHEDULER -- requirements
Module: matmul_tile_scheduler

Interface
REQ-001 SHALL have parameter INNER_BLOCKS, default 2: K-blocks per output tile (inner dimension / block size).
REQ-002 SHALL have parameter ROW_TILES, default 3: output-tile rows (input outer dimension / block size).
REQ-003 SHALL have parameter COL_TILES, default 3: output-tile columns (weight outer dimension / block size).
REQ-004 SHALL have parameters ADDR_WIDTH_I, ADDR_WIDTH_W and ADDR_WIDTH_O, default 4 each: input-BRAM, weight-BRAM and output address widths.
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock; one clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begins a full matrix job from IDLE or DONE.
- abort  in  1  synchronous; cancels the job.
- in_rd_en  out  1  input-BRAM port-B enable.
- in_rd_addr  out  ADDR_WIDTH_I  input-BRAM read address.
- wb_rd_en  out  1  weight-BRAM port-B enable.
- wb_rd_addr  out  ADDR_WIDTH_W  weight-BRAM read address.
- core_en  out  1  systolic core enable.
- core_rst_n  out  1  systolic reset, active-low.
- core_acc_clr_n  out  1  accumulator clear, active-low.
- core_sys_finish  in  1  core block-product complete.
- core_acc_done  in  1  core accumulation complete.
- out_wr_en  out  1  output-capture strobe.
- out_addr  out  ADDR_WIDTH_O  output tile index.
- out_ready  in  1  output sink accepts.
- busy  out  1  job in progress.
- done  out  1  job complete, sticky.

Function
REQ-006 SHALL implement the states IDLE, CLEAR, FETCH, RUN, NEXT, WAIT_ACC, WRITE and DONE.
REQ-007 SHALL keep counters k (0..INNER_BLOCKS-1), row (0..ROW_TILES-1) and col (0..COL_TILES-1), each 16 bits wide.
REQ-008 SHALL transition IDLE or DONE -> CLEAR when start=1, clearing k, row, col and done.
REQ-009 SHALL drive core_rst_n=0 and core_acc_clr_n=0 for exactly one cycle in CLEAR, then go to FETCH.
REQ-010 SHALL drive in_rd_en=wb_rd_en=1 in FETCH, with in_rd_addr=k+INNER_BLOCKS*row and wb_rd_addr=k+INNER_BLOCKS*col, truncated to the port widths.
REQ-011 SHALL hold FETCH for one cycle to cover the BRAM read latency of 1, then go to RUN.
REQ-012 SHALL hold the addresses stable from FETCH through RUN.
REQ-013 SHALL drive core_en=1 in RUN and stay in RUN until core_sys_finish=1, then go to NEXT.
REQ-014 SHALL drive core_rst_n=0 for one cycle in NEXT.
REQ-015 SHALL, in NEXT, go to WAIT_ACC if k==INNER_BLOCKS-1; otherwise it SHALL increment k and return to FETCH.
REQ-016 SHALL drive core_en=1 in WAIT_ACC and wait for core_acc_done=1, then go to WRITE with k=0.
REQ-017 SHALL drive out_wr_en=1 in WRITE with out_addr=row*COL_TILES+col, held until out_ready=1; the handshake completes in the cycle where out_wr_en and out_ready are both 1.
REQ-018 SHALL drive core_en=0 while WRITE waits (backpressure stalls the core).
REQ-019 SHALL, on write completion: go to DONE if row==ROW_TILES-1 and col==COL_TILES-1; otherwise increment col, or wrap col to 0 and increment row, and go to CLEAR.
REQ-020 SHALL set done=1 in DONE and hold it until the next start.
REQ-021 SHALL drive busy=1 in every state except IDLE and DONE.
REQ-022 SHALL treat start=1 outside IDLE and DONE as a no-op.
REQ-023 SHALL, on abort=1 in any state, go to IDLE next cycle with counters and done cleared; abort SHALL take priority over start and all other transitions in the same cycle.
REQ-024 SHALL register core_sys_finish or core_acc_done only in RUN or WAIT_ACC respectively; the strobes SHALL be ignored in any other state.
REQ-025 SHALL take the WRITE completion in the same cycle out_ready first rises, giving zero extra latency.
REQ-026 SHALL support INNER_BLOCKS=1, which gives a FETCH-RUN-NEXT-WAIT_ACC sequence per tile.

Reset
REQ-027 SHALL, on rst_n=0 (asynchronous): enter IDLE, clear k, row and col, and set the outputs to in_rd_en=0, wb_rd_en=0, addresses=0, core_en=0, core_rst_n=0, core_acc_clr_n=0, out_wr_en=0, out_addr=0, busy=0 and done=0.
REQ-028 SHALL, on rst_n deassertion, remain in IDLE until start.
REQ-029 SHALL drive core_rst_n=1 and core_acc_clr_n=1 in IDLE after reset is released.
REQ-030 SHALL abandon the job on reset mid-job with no output write.

Verification
REQ-031 SHALL verify the full job: defaults, a core model returning finish 4 cycles after core_en and acc_done after the 2nd finish, out_ready=1 -> 9 writes with out_addr 0..8 in order, 18 FETCHes, then done=1 and busy=0.
REQ-032 SHALL verify addressing: at tile row=1, col=2 -> in_rd_addr=2,3 and wb_rd_addr=4,5, with out_addr=5.
REQ-033 SHALL verify backpressure: out_ready=0 for 5 cycles at tile 0 -> out_wr_en held for 6 cycles, core_en=0 and out_addr stable, with 1 write accepted.
REQ-034 SHALL verify abort: abort in RUN of tile 4 -> IDLE next cycle, busy=0 and done=0; a subsequent start restarts at out_addr 0.
REQ-035 SHALL verify reset mid-job: rst_n=0 asynchronously mid-WAIT_ACC -> all outputs at reset values before the next clk edge.
REQ-036 SHALL verify spurious strobes and restart: core_sys_finish pulsed in IDLE is ignored; start while busy is ignored; start in DONE -> done=0 and CLEAR next cycle.
